// File: rtl/zz_block_assembler.sv
// rtl/zz_block_assembler.sv - scatters run/coef tokens into a ping-pong zigzag line buffer
// Blocks close on EOB, on index 63, or on overflow; completed lines leave via valid/ready.
module zz_block_assembler #(
   parameter int Q = 16,
   parameter int N = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_run,
   input  logic [Q-1:0]     in_coef,
   input  logic             in_eob,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N*Q-1:0]   out_line,
   output logic             err_ovf,
   output logic [15:0]      blk_cnt
);

   logic [1:0][N-1:0][Q-1:0] buf_q;
   logic                     wr_sel_q, rd_sel_q;
   logic [1:0]               full_cnt_q, full_cnt_d;
   logic [6:0]               idx_q, idx_d;
   logic                     err_ovf_q;
   logic [15:0]              blk_cnt_q;

   logic [7:0] t;
   logic       accept, hs, wr_en, ovf, close;

   assign in_ready  = (full_cnt_q != 2'd2);
   assign out_valid = (full_cnt_q != 2'd0);
   assign out_line  = buf_q[rd_sel_q];
   assign err_ovf   = err_ovf_q;
   assign blk_cnt   = blk_cnt_q;

   assign accept = in_valid && in_ready;
   assign hs     = out_valid && out_ready;
   assign t      = {1'b0, idx_q} + {2'b00, in_run};
   assign wr_en  = accept && !in_eob && (t <= 8'd63);
   assign ovf    = accept && !in_eob && (t > 8'd63);
   assign close  = accept && (in_eob || (t >= 8'd63));

   always_comb begin
      full_cnt_d = full_cnt_q;
      if (close && !hs)
         full_cnt_d = full_cnt_q + 2'd1;
      else if (hs && !close)
         full_cnt_d = full_cnt_q - 2'd1;

      idx_d = idx_q;
      if (close)
         idx_d = 7'd0;
      else if (wr_en)
         idx_d = t[6:0] + 7'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q      <= '0;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         full_cnt_q <= 2'd0;
         idx_q      <= 7'd0;
         err_ovf_q  <= 1'b0;
         blk_cnt_q  <= 16'd0;
      end else begin
         // The released buffer is the next fill buffer; it never collides with an active write.
         if (hs)
            buf_q[rd_sel_q] <= '0;
         if (wr_en)
            buf_q[wr_sel_q][t[5:0]] <= in_coef;
         if (close)
            wr_sel_q <= ~wr_sel_q;
         if (hs) begin
            rd_sel_q  <= ~rd_sel_q;
            blk_cnt_q <= blk_cnt_q + 16'd1;
         end
         full_cnt_q <= full_cnt_d;
         idx_q      <= idx_d;
         err_ovf_q  <= ovf;
      end
   end

endmodule

// File: tb/tb_zz_block_assembler.sv
// tb/tb_zz_block_assembler.sv - table-driven and scoreboard bench for zz_block_assembler
module tb_zz_block_assembler;
   localparam int Q = 16;
   localparam int N = 64;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, in_eob;
   logic [5:0]       in_run;
   logic [Q-1:0]     in_coef;
   logic             out_valid, out_ready;
   logic [N*Q-1:0]   out_line;
   logic             err_ovf;
   logic [15:0]      blk_cnt;

   zz_block_assembler #(.Q(Q), .N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_run(in_run),
      .in_coef(in_coef), .in_eob(in_eob),
      .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
      .err_ovf(err_ovf), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]   run;
      logic [Q-1:0] coef;
      logic         eob;
      logic         exp_ovf;
   } vec_t;

   int             n_cmp = 0;
   int             n_err = 0;
   int             hs_count = 0;
   logic [N*Q-1:0] exp_q[$];
   int             midx = 0;
   logic [N*Q-1:0] mline = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_line(input string name, input logic [N*Q-1:0] act, input logic [N*Q-1:0] exp);
      int bad;
      bad = -1;
      n_cmp++;
      for (int i = N - 1; i >= 0; i--)
         if (act[i*Q +: Q] !== exp[i*Q +: Q]) bad = i;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL %s: line[%0d] got %0h expected %0h at %0t",
                  name, bad, act[bad*Q +: Q], exp[bad*Q +: Q], $time);
      end
   endtask

   function automatic void model_accept(input logic [5:0] run, input logic [Q-1:0] coef, input logic eob);
      int tt;
      tt = midx + int'(run);
      if (eob || tt > 63) begin
         exp_q.push_back(mline);
         mline = '0;
         midx  = 0;
      end else begin
         mline[tt*Q +: Q] = coef;
         midx = tt + 1;
         if (tt == 63) begin
            exp_q.push_back(mline);
            mline = '0;
            midx  = 0;
         end
      end
   endfunction

   // Called just after a rising edge; returns just after the edge that accepts the token.
   task automatic send(input logic [5:0] run, input logic [Q-1:0] coef, input logic eob);
      int cnt;
      in_valid = 1'b1;
      in_run   = run;
      in_coef  = coef;
      in_eob   = eob;
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", cnt);
      end else begin
         model_accept(run, coef, eob);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: handshake with no expected block at %0t", $time);
         end else begin
            chk_line("sb_line", out_line, exp_q.pop_front());
         end
         chk("blk_cnt", {16'd0, blk_cnt}, hs_count);
         hs_count++;
      end
   end

   vec_t vt [14];

   initial begin
      vt[0]  = '{6'd0,  16'd5,      1'b0, 1'b0};
      vt[1]  = '{6'd2,  16'hFFFD,   1'b0, 1'b0};
      vt[2]  = '{6'd0,  16'd0,      1'b1, 1'b0};
      vt[3]  = '{6'd0,  16'd7,      1'b0, 1'b0};
      vt[4]  = '{6'd63, 16'd1,      1'b0, 1'b1};
      vt[5]  = '{6'd0,  16'd2,      1'b0, 1'b0};
      vt[6]  = '{6'd0,  16'd0,      1'b1, 1'b0};
      vt[7]  = '{6'd15, 16'd0,      1'b0, 1'b0};
      vt[8]  = '{6'd0,  16'd4,      1'b0, 1'b0};
      vt[9]  = '{6'd0,  16'd0,      1'b1, 1'b0};
      vt[10] = '{6'd0,  16'd0,      1'b1, 1'b0};
      vt[11] = '{6'd63, 16'hFFFF,   1'b0, 1'b0};
      vt[12] = '{6'd1,  16'd8,      1'b0, 1'b0};
      vt[13] = '{6'd62, 16'd9,      1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_run = '0; in_coef = '0; in_eob = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_err_ovf", err_ovf, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk_line("rst_line", out_line, '0);

      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         send(vt[i].run, vt[i].coef, vt[i].eob);
         chk($sformatf("vec%0d_ovf", i), err_ovf, vt[i].exp_ovf);
      end
      @(posedge clk); #1;
      chk("ovf_one_cycle", err_ovf, 0);
      drain();

      send(6'd3, 16'd77, 1'b0);
      chk("latency_pre", out_valid, 0);
      send(6'd0, 16'd0, 1'b1);
      chk("latency_eob", out_valid, 1);
      drain();

      for (int i = 0; i < 64; i++) begin
         send(6'd0, 16'(i + 1), 1'b0);
         if (i == 62) chk("full64_open", out_valid, 0);
      end
      chk("full64_close", out_valid, 1);
      send(6'd0, 16'd0, 1'b1);
      drain();

      out_ready = 1'b0;
      send(6'd0, 16'd11, 1'b0); send(6'd0, 16'd12, 1'b0); send(6'd0, 16'd13, 1'b0);
      send(6'd0, 16'd0, 1'b1);
      send(6'd1, 16'd22, 1'b0); send(6'd0, 16'd0, 1'b1);
      chk("stall_in_ready", in_ready, 0);
      in_valid = 1'b1; in_run = 6'd0; in_coef = 16'd33; in_eob = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_held", in_ready, 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("stall_release", in_ready, 1);
      chk("stall_valid", out_valid, 1);
      chk_line("stall_blk2", out_line, exp_q[0]);
      @(negedge clk);
      model_accept(6'd0, 16'd33, 1'b0);
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_line("stall_blk2_stable", out_line, exp_q[0]);
      send(6'd0, 16'd0, 1'b1);
      drain();

      out_ready = 1'b0;
      send(6'd0, 16'd44, 1'b0); send(6'd0, 16'd0, 1'b1);
      send(6'd0, 16'd55, 1'b0);
      in_valid = 1'b1; in_eob = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      model_accept(6'd0, 16'd0, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0; in_eob = 1'b0; out_ready = 1'b0;
      chk("simul_valid", out_valid, 1);
      chk("simul_in_ready", in_ready, 1);
      chk_line("simul_line", out_line, exp_q[0]);
      drain();

      out_ready = 1'b0;
      send(6'd0, 16'd66, 1'b0); send(6'd0, 16'd0, 1'b1);
      send(6'd0, 16'd9, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_blk_cnt", blk_cnt, 0);
      chk("arst_in_ready", in_ready, 1);
      chk_line("arst_line", out_line, '0);
      exp_q.delete();
      midx = 0; mline = '0; hs_count = 0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(6'd0, 16'd0, 1'b1);
      drain();

      chk("sb_drained", exp_q.size(), 0);
      chk("final_blk_cnt", {16'd0, blk_cnt}, hs_count);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
